// File: rtl/unified_mem_arbiter_if.sv
// Bus bundle for the unified memory arbiter: fetch port, data port and the
// single-port memory side.
interface unified_mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_rdata;
   logic              if_valid;
   logic              if_stall;

   logic              dm_req;
   logic              dm_we;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic [DATA_W-1:0] dm_rdata;
   logic              dm_valid;
   logic              dm_stall;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   // Arbiter side: serves the two pipeline ports and drives the memory.
   modport slave (
      input  if_req, if_addr,
      output if_rdata, if_valid, if_stall,
      input  dm_req, dm_we, dm_addr, dm_wdata,
      output dm_rdata, dm_valid, dm_stall,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );

   // Environment side: pipeline requesters plus the memory array.
   modport master (
      output if_req, if_addr,
      input  if_rdata, if_valid, if_stall,
      output dm_req, dm_we, dm_addr, dm_wdata,
      input  dm_rdata, dm_valid, dm_stall,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Arbitrates a single-port memory between instruction fetch and data access,
// favouring data but bounding how long a waiting fetch can be starved.
module unified_mem_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int MEM_LAT    = 2,
   parameter int STARVE_MAX = 3
) (
   input logic                  clk,
   input logic                  rst,
   unified_mem_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, BUSY_I = 2'd1, BUSY_D = 2'd2} state_t;

   localparam logic [3:0] LAT_M1     = 4'(MEM_LAT - 1);
   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   state_t            state_r, state_s;
   logic [3:0]        cnt_r, cnt_s;
   logic [3:0]        starve_r, starve_s;
   logic [ADDR_W-1:0] addr_r, addr_s;
   logic [DATA_W-1:0] wdata_r, wdata_s;
   logic              we_r, we_s;
   logic [DATA_W-1:0] if_rdata_r, if_rdata_s, dm_rdata_r, dm_rdata_s;
   logic              if_valid_r, if_valid_s, dm_valid_r, dm_valid_s;
   logic              if_elig_s, dm_elig_s, grant_d_s, grant_i_s;

   // Eligibility excludes a port in its own valid cycle so a held request is not re-granted.
   always_comb begin
      if_elig_s = bus.if_req & ~if_valid_r;
      dm_elig_s = bus.dm_req & ~dm_valid_r;
      if (state_r == IDLE) begin
         grant_d_s = dm_elig_s & (~if_elig_s | (starve_r != STARVE_LIM));
         grant_i_s = if_elig_s & ~grant_d_s;
      end else begin
         grant_d_s = 1'b0;
         grant_i_s = 1'b0;
      end
   end

   // Next state, busy counter, starvation counter and completion capture.
   always_comb begin
      state_s    = state_r;
      cnt_s      = cnt_r;
      starve_s   = starve_r;
      addr_s     = addr_r;
      wdata_s    = wdata_r;
      we_s       = we_r;
      if_rdata_s = if_rdata_r;
      dm_rdata_s = dm_rdata_r;
      if_valid_s = 1'b0;
      dm_valid_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (grant_d_s) begin
               state_s = BUSY_D;
               cnt_s   = LAT_M1;
               addr_s  = bus.dm_addr;
               wdata_s = bus.dm_wdata;
               we_s    = bus.dm_we;
               if (bus.if_req && (starve_r != STARVE_LIM)) begin
                  starve_s = starve_r + 4'd1;
               end else begin
                  starve_s = starve_r;
               end
            end else if (grant_i_s) begin
               state_s  = BUSY_I;
               cnt_s    = LAT_M1;
               addr_s   = bus.if_addr;
               wdata_s  = {DATA_W{1'b0}};
               we_s     = 1'b0;
               starve_s = 4'd0;
            end else begin
               state_s = IDLE;
            end
         end
         BUSY_I, BUSY_D: begin
            if (cnt_r != 4'd0) begin
               cnt_s = cnt_r - 4'd1;
            end else begin
               state_s = IDLE;
               if (state_r == BUSY_I) begin
                  if_rdata_s = bus.mem_rdata;
                  if_valid_s = 1'b1;
               end else begin
                  dm_rdata_s = bus.mem_rdata;
                  dm_valid_s = 1'b1;
               end
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= IDLE;
         cnt_r      <= 4'd0;
         starve_r   <= 4'd0;
         addr_r     <= {ADDR_W{1'b0}};
         wdata_r    <= {DATA_W{1'b0}};
         we_r       <= 1'b0;
         if_rdata_r <= {DATA_W{1'b0}};
         dm_rdata_r <= {DATA_W{1'b0}};
         if_valid_r <= 1'b0;
         dm_valid_r <= 1'b0;
      end else begin
         state_r    <= state_s;
         cnt_r      <= cnt_s;
         starve_r   <= starve_s;
         addr_r     <= addr_s;
         wdata_r    <= wdata_s;
         we_r       <= we_s;
         if_rdata_r <= if_rdata_s;
         dm_rdata_r <= dm_rdata_s;
         if_valid_r <= if_valid_s;
         dm_valid_r <= dm_valid_s;
      end
   end

   // The write strobe is gated by rst so a reset in the last busy cycle aborts the store.
   assign bus.mem_en    = (state_r != IDLE);
   assign bus.mem_we    = (state_r == BUSY_D) & (cnt_r == 4'd0) & we_r & ~rst;
   assign bus.mem_addr  = (state_r != IDLE) ? addr_r  : {ADDR_W{1'b0}};
   assign bus.mem_wdata = (state_r != IDLE) ? wdata_r : {DATA_W{1'b0}};

   assign bus.if_rdata  = if_rdata_r;
   assign bus.if_valid  = if_valid_r;
   assign bus.if_stall  = bus.if_req & ~if_valid_r;
   assign bus.dm_rdata  = dm_rdata_r;
   assign bus.dm_valid  = dm_valid_r;
   assign bus.dm_stall  = bus.dm_req & ~dm_valid_r;
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter (MEM_LAT=2, STARVE_MAX=3) with a
// word-addressed memory model whose unwritten words hold a known pattern.
module tb_unified_mem_arbiter;
   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   int   we_count = 0;

   unified_mem_arbiter_if bus ();

   unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: written words override the initial pattern.
   logic [31:0] mem_data [0:255];
   bit          mem_vld  [0:255];

   function automatic logic [31:0] init_word(input logic [31:0] a);
      return 32'hC0DE_0000 ^ a;
   endfunction

   function automatic logic [31:0] rd_model(input logic [31:0] a);
      logic [7:0] idx;
      idx = a[9:2];
      return mem_vld[idx] ? mem_data[idx] : init_word({a[31:2], 2'b00});
   endfunction

   assign bus.mem_rdata = rd_model(bus.mem_addr);

   always @(posedge clk) begin
      if (bus.mem_we === 1'b1) begin
         mem_data[bus.mem_addr[9:2]] <= bus.mem_wdata;
         mem_vld[bus.mem_addr[9:2]]  <= 1'b1;
         we_count                    <= we_count + 1;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic        is_data;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t        vecs [7];
   logic [31:0] last_if;
   logic [31:0] last_dm;

   // Single isolated transaction; starts at posedge+1 with the arbiter idle.
   task automatic run_txn(input int id, input vec_t v);
      bit act;
      if (v.is_data) begin
         bus.dm_req = 1'b1; bus.dm_we = v.we; bus.dm_addr = v.addr; bus.dm_wdata = v.wdata;
      end else begin
         bus.if_req = 1'b1; bus.if_addr = v.addr;
      end
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         act = (k == 1) || (k == 2);
         chk($sformatf("v%0d.c%0d mem_en", id, k), bus.mem_en, act);
         chk($sformatf("v%0d.c%0d mem_we", id, k), bus.mem_we, v.is_data && v.we && (k == 2));
         chk($sformatf("v%0d.c%0d mem_addr", id, k), bus.mem_addr, act ? v.addr : 32'h0);
         chk($sformatf("v%0d.c%0d mem_wdata", id, k), bus.mem_wdata,
             (act && v.is_data) ? v.wdata : 32'h0);
         chk($sformatf("v%0d.c%0d if_valid", id, k), bus.if_valid, !v.is_data && (k == 3));
         chk($sformatf("v%0d.c%0d dm_valid", id, k), bus.dm_valid, v.is_data && (k == 3));
         chk($sformatf("v%0d.c%0d if_stall", id, k), bus.if_stall, !v.is_data && (k < 3));
         chk($sformatf("v%0d.c%0d dm_stall", id, k), bus.dm_stall, v.is_data && (k < 3));
         if (k == 3) begin
            if (v.is_data) last_dm = v.exp_rdata;
            else           last_if = v.exp_rdata;
            chk($sformatf("v%0d if_rdata", id), bus.if_rdata, last_if);
            chk($sformatf("v%0d dm_rdata", id), bus.dm_rdata, last_dm);
         end
         tick();
      end
      bus.if_req = 1'b0; bus.dm_req = 1'b0; bus.dm_we = 1'b0;
      tick();
   endtask

   logic [31:0] grants [$];
   logic [31:0] exp_grants [4];
   logic        prev_en;
   bit          done;
   int          wc0;

   initial begin
      rst = 1'b1;
      bus.if_req = 1'b0; bus.if_addr = 32'h0;
      bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = 32'h0; bus.dm_wdata = 32'h0;
      last_if = 32'h0; last_dm = 32'h0;

      vecs[0] = '{1'b0, 1'b0, 32'h10, 32'h0,         init_word(32'h10)};
      vecs[1] = '{1'b1, 1'b0, 32'h40, 32'h0,         init_word(32'h40)};
      vecs[2] = '{1'b1, 1'b1, 32'h80, 32'hDEADBEEF,  init_word(32'h80)};
      vecs[3] = '{1'b1, 1'b0, 32'h80, 32'h0,         32'hDEADBEEF};
      vecs[4] = '{1'b0, 1'b0, 32'h80, 32'h0,         32'hDEADBEEF};
      vecs[5] = '{1'b1, 1'b1, 32'h84, 32'h12345678,  init_word(32'h84)};
      vecs[6] = '{1'b0, 1'b0, 32'h84, 32'h0,         32'h12345678};

      tick();
      tick();
      @(negedge clk);
      chk("reset if_valid", bus.if_valid, 1'b0);
      chk("reset dm_valid", bus.dm_valid, 1'b0);
      chk("reset if_rdata", bus.if_rdata, 32'h0);
      chk("reset dm_rdata", bus.dm_rdata, 32'h0);
      chk("reset mem_en", bus.mem_en, 1'b0);
      chk("reset mem_addr", bus.mem_addr, 32'h0);
      tick();
      rst = 1'b0;
      tick();

      for (int i = 0; i < 7; i++) run_txn(i, vecs[i]);
      chk("store write count", we_count, 32'd2);

      // Simultaneous fetch and load: data first, fetch granted in the dm_valid cycle.
      bus.if_req = 1'b1; bus.if_addr = 32'h10;
      bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h40;
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         chk($sformatf("both.c%0d mem_en", k), bus.mem_en, (k == 1) || (k == 2) || (k == 4) || (k == 5));
         chk($sformatf("both.c%0d mem_addr", k), bus.mem_addr,
             ((k == 1) || (k == 2)) ? 32'h40 : (((k == 4) || (k == 5)) ? 32'h10 : 32'h0));
         chk($sformatf("both.c%0d dm_valid", k), bus.dm_valid, k == 3);
         chk($sformatf("both.c%0d if_valid", k), bus.if_valid, k == 6);
         chk($sformatf("both.c%0d dm_stall", k), bus.dm_stall, k < 3);
         chk($sformatf("both.c%0d if_stall", k), bus.if_stall, k < 6);
         if (k == 3) chk("both dm_rdata", bus.dm_rdata, init_word(32'h40));
         if (k == 6) chk("both if_rdata", bus.if_rdata, init_word(32'h10));
         tick();
         if (k == 3) bus.dm_req = 1'b0;
      end
      bus.if_req = 1'b0;
      last_dm = init_word(32'h40);
      last_if = init_word(32'h10);
      tick();

      // Starvation: data requested back-to-back, fetch pending between completions.
      exp_grants[0] = 32'h40; exp_grants[1] = 32'h44; exp_grants[2] = 32'h48; exp_grants[3] = 32'h10;
      bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h40;
      bus.if_req = 1'b1; bus.if_addr = 32'h10;
      prev_en = 1'b0;
      done = 1'b0;
      for (int c = 0; c < 60 && !done; c++) begin
         @(negedge clk);
         if (bus.mem_en && !prev_en) begin
            grants.push_back(bus.mem_addr);
            if (grants.size() == 3) chk("starve after 3 data", dut.starve_r, 32'd3);
            if (grants.size() == 4) chk("starve after fetch", dut.starve_r, 32'd0);
         end
         prev_en = bus.mem_en;
         tick();
         if (bus.if_valid) begin
            done = 1'b1;
            chk("starve if_rdata", bus.if_rdata, init_word(32'h10));
            bus.if_req = 1'b0;
            bus.dm_req = 1'b0;
         end else if (bus.dm_valid) begin
            chk($sformatf("starve dm_rdata %h", bus.dm_addr), bus.dm_rdata, init_word(bus.dm_addr));
            bus.dm_addr = bus.dm_addr + 32'h4;
            bus.if_req = 1'b0;
         end else begin
            bus.if_req = 1'b1;
         end
      end
      chk("starve completed", done, 1'b1);
      chk("starve grant count", grants.size(), 32'd4);
      for (int i = 0; i < 4; i++) begin
         if (i < grants.size()) chk($sformatf("starve grant %0d", i), grants[i], exp_grants[i]);
      end
      tick();

      // Reset in the final busy cycle of a store aborts it.
      wc0 = we_count;
      bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 32'h90; bus.dm_wdata = 32'h55AA55AA;
      tick();
      tick();
      rst = 1'b1;
      @(negedge clk);
      chk("rst busy mem_en", bus.mem_en, 1'b1);
      chk("rst busy mem_we", bus.mem_we, 1'b0);
      tick();
      bus.dm_req = 1'b0; bus.dm_we = 1'b0;
      @(negedge clk);
      chk("rst dm_valid", bus.dm_valid, 1'b0);
      chk("rst mem_en", bus.mem_en, 1'b0);
      chk("rst cnt", dut.cnt_r, 32'd0);
      chk("rst we_count", we_count, wc0);
      chk("rst memory", rd_model(32'h90), init_word(32'h90));
      chk("rst dm_rdata", bus.dm_rdata, 32'h0);
      chk("rst if_rdata", bus.if_rdata, 32'h0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("post rst dm_valid", bus.dm_valid, 1'b0);
      chk("post rst mem_en", bus.mem_en, 1'b0);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/unified_mem_arbiter.md
UNIFIED_MEM_ARBITER -- requirements
Module: unified_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, memory address width in bits.
REQ-002 Parameter DATA_W, default 32, memory data width in bits.
REQ-003 Parameter MEM_LAT, default 2, number of cycles one memory access occupies the port; legal range 1..15.
REQ-004 Parameter STARVE_MAX, default 3, maximum consecutive data-port grants while a fetch request waits; legal range 1..15.
REQ-005 The block SHALL use a single clock and a synchronous, active-high reset.
REQ-006 clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 if_req  input  1  fetch-stage read request, level, held until if_valid.
REQ-009 if_addr  input  ADDR_W  fetch address.
REQ-010 if_rdata  output  DATA_W  fetched instruction, registered.
REQ-011 if_valid  output  1  one-cycle pulse; if_rdata valid.
REQ-012 if_stall  output  1  if_req AND NOT if_valid; freezes PC/IF-ID.
REQ-013 dm_req  input  1  MEM-stage access request, level, held until dm_valid.
REQ-014 dm_we  input  1  1 = write, 0 = read.
REQ-015 dm_addr, dm_wdata  input  ADDR_W, DATA_W  data address and write data.
REQ-016 dm_rdata  output  DATA_W  load data, registered.
REQ-017 dm_valid  output  1  one-cycle pulse; access done (reads and writes).
REQ-018 dm_stall  output  1  dm_req AND NOT dm_valid; freezes the whole pipeline.
REQ-019 mem_en, mem_we  output  1, 1  single-port memory enable and write strobe.
REQ-020 mem_addr, mem_wdata  output  ADDR_W, DATA_W  memory address and write data.
REQ-021 mem_rdata  input  DATA_W  memory read data, combinational on mem_addr.

Function
REQ-022 FSM states SHALL be IDLE, BUSY_I, BUSY_D; a down-counter cnt of 4 bits tracks the remaining busy cycles.
REQ-023 In IDLE, a requester SHALL be eligible only if its req is 1 and its valid is 0 in that cycle.
REQ-024 If only one requester is eligible, it SHALL be granted: next state BUSY_I or BUSY_D, cnt <= MEM_LAT-1, and address, wdata and we latched.
REQ-025 If both are eligible, the data port SHALL win unless starve_cnt == STARVE_MAX, in which case fetch SHALL win.
REQ-026 starve_cnt SHALL increment on each data grant made while if_req=1, saturate at STARVE_MAX, and clear on every fetch grant.
REQ-027 In BUSY_x, mem_en=1 and mem_addr/mem_wdata SHALL equal the latched values; request inputs changing mid-access SHALL be ignored.
REQ-028 When cnt>0, cnt SHALL decrement each cycle.
REQ-029 When cnt==0: the granted rdata register <= mem_rdata, the granted valid <= 1 for exactly one cycle, and next state = IDLE.
REQ-030 mem_we SHALL be 1 only in BUSY_D with cnt==0, latched we=1 and rst=0, giving exactly one write per store.
REQ-031 Latency: req first seen in IDLE in cycle 0 -> valid high in cycle MEM_LAT+1; minimum spacing between grants is MEM_LAT+1 cycles.
REQ-032 If req drops mid-access, the access SHALL still complete and valid SHALL still pulse; a write SHALL still be performed.
REQ-033 In IDLE, mem_en, mem_we, mem_addr and mem_wdata SHALL be 0.
REQ-034 if_rdata and dm_rdata SHALL hold their last value until the next completion on that port.

Reset
REQ-035 On rst=1 at a clock edge: state=IDLE, cnt=0, starve_cnt=0, if_valid=dm_valid=0, and if_rdata=dm_rdata=0.
REQ-036 A reset during BUSY_x SHALL abort the access with no valid pulse, and mem_we SHALL be 0 in the reset cycle.

Verification
REQ-037 With MEM_LAT=2, if_req=1 and if_addr=0x10 alone -> mem_en high in cycles 1-2, if_valid in cycle 3, if_rdata=mem[0x10].
REQ-038 if_req and dm_req (load, addr 0x40) rise together -> data granted first, dm_valid in cycle 3, fetch granted in cycle 3, if_valid in cycle 6.
REQ-039 dm_req held continuously with new addresses each completion, if_req pending, STARVE_MAX=3 -> exactly 3 data grants, then a fetch grant, then starve_cnt=0.
REQ-040 Store dm_we=1, addr 0x80, wdata 0xDEADBEEF -> exactly one mem_we cycle; a later load from 0x80 returns 0xDEADBEEF.
REQ-041 rst asserted during the final BUSY_D cycle of a store -> no mem_we, no dm_valid, state IDLE; memory unchanged.
REQ-042 Stall outputs -> if_stall and dm_stall track req AND NOT valid in every cycle of scenarios REQ-037 through REQ-040.
